// File: rtl/coproc_lane_alu.sv
// Lane-wise streaming coprocessor: per-lane PASS/DELAY/ADD/SUB/XOR/ACC over a frame history.
// Latency 1 cycle (registered output); one frame per cycle sustained when dout_ready=1.
// Backpressure: din_ready = !dout_valid || dout_ready; a stalled result holds dout/dout_valid.
//
// Ports:
//   clk, rst (async, active-low)
//   din/din_valid/din_ready   : input frame handshake
//   mode, tap                 : operation select / history index, sampled on acceptance
//   clear                     : synchronous clear of history, accumulator and count
//   dout/dout_valid/dout_ready: registered result handshake
//   count                     : 16-bit accepted-frame counter (wraps)
// Optional build macro: COPROC_SATURATE_EN (ADD/SUB/ACC lanes saturate unsigned instead of wrapping).
// WIDTH must be a multiple of LANE_W; DEPTH must be a power of two (>= 2).

module coproc_lane_alu #(
    parameter int WIDTH  = 144,
    parameter int LANE_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         din,
    input  logic                     din_valid,
    output logic                     din_ready,
    input  logic [2:0]               mode,
    input  logic [$clog2(DEPTH)-1:0] tap,
    input  logic                     clear,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [15:0]              count
);

    localparam int LANES = WIDTH / LANE_W;

    localparam logic [2:0] MODE_PASS  = 3'd0;
    localparam logic [2:0] MODE_DELAY = 3'd1;
    localparam logic [2:0] MODE_ADD   = 3'd2;
    localparam logic [2:0] MODE_SUB   = 3'd3;
    localparam logic [2:0] MODE_XOR   = 3'd4;
    localparam logic [2:0] MODE_ACC   = 3'd5;

    // State
    logic [WIDTH-1:0] r_hist [DEPTH];
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic [15:0]      r_count;

    // Combinational
    logic             w_accept;
    logic [WIDTH-1:0] w_h0;
    logic [WIDTH-1:0] w_tap_val;
    logic [WIDTH-1:0] w_acc;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_result;

    // Per-lane unsigned add; carries never leave the lane.
    function automatic logic [LANE_W-1:0] lane_add(input logic [LANE_W-1:0] a,
                                                   input logic [LANE_W-1:0] b);
`ifdef COPROC_SATURATE_EN
        logic [LANE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[LANE_W] ? {LANE_W{1'b1}} : s[LANE_W-1:0];
`else
        return a + b;
`endif
    endfunction

    // Per-lane unsigned subtract; borrows never leave the lane.
    function automatic logic [LANE_W-1:0] lane_sub(input logic [LANE_W-1:0] a,
                                                   input logic [LANE_W-1:0] b);
`ifdef COPROC_SATURATE_EN
        logic [LANE_W:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[LANE_W] ? {LANE_W{1'b0}} : d[LANE_W-1:0];
`else
        return a - b;
`endif
    endfunction

    assign din_ready  = !r_dout_valid || dout_ready;
    assign w_accept   = din_valid && din_ready;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign count      = r_count;

    // A clear coinciding with an accept makes the frame see zeroed history and
    // accumulator, so the operands are masked here rather than in the registers.
    assign w_h0      = clear ? '0 : r_hist[0];
    assign w_tap_val = clear ? '0 : r_hist[tap];
    assign w_acc     = clear ? '0 : r_acc;

    always_comb begin
        w_sum      = '0;
        w_diff     = '0;
        w_acc_next = '0;
        for (int l = 0; l < LANES; l++) begin
            w_sum[l*LANE_W +: LANE_W]      = lane_add(din[l*LANE_W +: LANE_W], w_h0[l*LANE_W +: LANE_W]);
            w_diff[l*LANE_W +: LANE_W]     = lane_sub(din[l*LANE_W +: LANE_W], w_h0[l*LANE_W +: LANE_W]);
            w_acc_next[l*LANE_W +: LANE_W] = lane_add(w_acc[l*LANE_W +: LANE_W], din[l*LANE_W +: LANE_W]);
        end
    end

    // Reserved modes 6 and 7 fall through to PASS.
    always_comb begin
        w_result = din;
        case (mode)
            MODE_PASS:  w_result = din;
            MODE_DELAY: w_result = w_tap_val;
            MODE_ADD:   w_result = w_sum;
            MODE_SUB:   w_result = w_diff;
            MODE_XOR:   w_result = din ^ w_h0;
            MODE_ACC:   w_result = w_acc_next;
            default:    w_result = din;
        endcase
    end

    // Single-stage output register: load on accept, drop valid when drained.
    // Clear deliberately leaves the output untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else if (w_accept) begin
            r_dout       <= w_result;
            r_dout_valid <= 1'b1;
        end else if (dout_ready) begin
            r_dout_valid <= 1'b0;
        end
    end

    // History shift register; hist[0] is the most recent previously accepted frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_hist[k] <= '0;
            end
        end else if (w_accept) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                r_hist[k] <= clear ? '0 : r_hist[k-1];
            end
            r_hist[0] <= din;
        end else if (clear) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_hist[k] <= '0;
            end
        end
    end

    // Accumulator moves only on ACC-mode accepts; otherwise only clear touches it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= '0;
        end else if (w_accept && (mode == MODE_ACC)) begin
            r_acc <= w_acc_next;
        end else if (clear) begin
            r_acc <= '0;
        end
    end

    // Accepted-frame counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= (clear ? 16'd0 : r_count) + 16'd1;
        end else if (clear) begin
            r_count <= '0;
        end
    end

endmodule

// File: tb/tb_coproc_lane_alu.sv
module tb_coproc_lane_alu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] din = '0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [2:0]  mode = '0;
    logic [1:0]  tap = '0;
    logic        clear = 1'b0;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready = 1'b1;
    logic [15:0] count;

    coproc_lane_alu #(.WIDTH(16), .LANE_W(8), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .mode       (mode),
        .tap        (tap),
        .clear      (clear),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .count      (count)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_err  = 0;
    int n_push = 0;
    int n_pop  = 0;

    logic [15:0] sb_q[$];

    // Reference model state
    logic [15:0] m_hist [4];
    logic [15:0] m_acc;
    logic [15:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_add(input int a, input int b);
        int s;
        s = a + b;
`ifdef COPROC_SATURATE_EN
        return (s > 255) ? 255 : s;
`else
        return s & 255;
`endif
    endfunction

    function automatic int m_sub(input int a, input int b);
        int s;
        s = a - b;
`ifdef COPROC_SATURATE_EN
        return (s < 0) ? 0 : s;
`else
        return s & 255;
`endif
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 4; k++) m_hist[k] = '0;
        m_acc = '0;
        m_cnt = '0;
    endtask

    // Called at the negedge before the edge where the frame is accepted.
    task automatic model_accept(input logic [15:0] d, input logic [2:0] m,
                                input logic [1:0] t, input bit clr);
        int a, b, c, h, r, e;
        if (clr) model_clear();
        e = 0;
        for (int l = 0; l < 2; l++) begin
            a = (int'(d) >> (8*l)) & 255;
            b = (int'(m_hist[0]) >> (8*l)) & 255;
            c = (int'(m_acc) >> (8*l)) & 255;
            h = (int'(m_hist[t]) >> (8*l)) & 255;
            case (m)
                3'd1:    r = h;
                3'd2:    r = m_add(a, b);
                3'd3:    r = m_sub(a, b);
                3'd4:    r = a ^ b;
                3'd5:    r = m_add(c, a);
                default: r = a;
            endcase
            e = e | (r << (8*l));
        end
        if (m == 3'd5) m_acc = e[15:0];
        for (int k = 3; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = d;
        m_cnt = m_cnt + 16'd1;
        sb_q.push_back(e[15:0]);
        n_push++;
    endtask

    // Drive one frame, wait (bounded) for acceptance; returns #1 after the accepting edge.
    task automatic send(input logic [15:0] d, input logic [2:0] m,
                        input logic [1:0] t, input bit clr = 1'b0);
        bit ok;
        ok = 1'b0;
        din = d; mode = m; tap = t; clear = clr; din_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (din_ready) begin
                model_accept(d, m, t, clr);
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", din_ready, 1);
        @(posedge clk); #1;
        din_valid = 1'b0;
        clear = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        n_push -= sb_q.size();
        sb_q.delete();
        model_clear();
        #1;
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_count", count, 0);
        chk("rst_din_ready", din_ready, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    // Scoreboard: every output handshake pops one expected frame.
    always @(negedge clk) begin
        if (rst === 1'b1 && dout_valid && dout_ready) begin
            chk("sb_nonempty", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
                chk("sb_data", dout, sb_q.pop_front());
                n_pop++;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] c0;

        // Reset state
        do_reset();

        // ADD / SUB lane carry behaviour
        send(16'h01FF, 3'd2, 2'd0);
        chk("add_first", dout, 16'h01FF);
        send(16'h0102, 3'd2, 2'd0);
`ifdef COPROC_SATURATE_EN
        chk("add_lane", dout, 16'h02FF);
`else
        chk("add_lane", dout, 16'h0201);
`endif
        send(16'h0001, 3'd3, 2'd0);
`ifdef COPROC_SATURATE_EN
        chk("sub_lane", dout, 16'h0000);
`else
        chk("sub_lane", dout, 16'hFFFF);
`endif

        // DELAY taps from a fresh history
        do_reset();
        send(16'h1111, 3'd1, 2'd3);
        chk("delay_tap3_fresh", dout, 16'h0000);
        send(16'h2222, 3'd1, 2'd1);
        chk("delay_tap1_b", dout, 16'h0000);
        send(16'h3333, 3'd1, 2'd1);
        chk("delay_tap1_c", dout, 16'h1111);

        // XOR with hist[0]
        send(16'hF0F0, 3'd4, 2'd0);
        chk("xor", dout, 16'hC3C3);

        // Backpressure
        @(posedge clk); #1;
        chk("bp_drained", dout_valid, 0);
        dout_ready = 1'b0;
        c0 = count;
        din = 16'hAAAA; mode = 3'd0; tap = 2'd0; din_valid = 1'b1;
        @(negedge clk);
        chk("bp_first_ready", din_ready, 1);
        model_accept(16'hAAAA, 3'd0, 2'd0, 1'b0);
        @(posedge clk); #1;
        din = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ready_low", din_ready, 0);
            chk("bp_dout_hold", dout, 16'hAAAA);
            chk("bp_valid_hold", dout_valid, 1);
            chk("bp_count", count, c0 + 16'd1);
        end
        @(posedge clk); #1;
        dout_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", din_ready, 1);
        model_accept(16'h5555, 3'd0, 2'd0, 1'b0);
        @(posedge clk); #1;
        din_valid = 1'b0;
        chk("bp_second", dout, 16'h5555);
        chk("bp_count2", count, c0 + 16'd2);

        // Accumulator and clear
        send(16'h0101, 3'd5, 2'd0);
        chk("acc_1", dout, 16'h0101);
        send(16'h0101, 3'd5, 2'd0);
        chk("acc_2", dout, 16'h0202);
        send(16'h0101, 3'd5, 2'd0);
        chk("acc_3", dout, 16'h0303);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_clear();
        chk("clear_count", count, 0);
        chk("clear_dout_kept", dout, 16'h0303);
        send(16'h0101, 3'd5, 2'd0);
        chk("acc_after_clear", dout, 16'h0101);
        chk("acc_count", count, 1);

        // Clear coinciding with an accept
        send(16'h0505, 3'd2, 2'd0, 1'b1);
        chk("clr_acc_result", dout, 16'h0505);
        chk("clr_acc_count", count, 1);
        send(16'h0000, 3'd1, 2'd1);
        chk("clr_acc_hist1", dout, 16'h0000);
        send(16'h0001, 3'd5, 2'd0);
        chk("clr_acc_acc", dout, 16'h0001);
        chk("clr_acc_count3", count, 3);

        // Async reset with a pending result
        @(posedge clk); #1;
        dout_ready = 1'b0;
        send(16'h1234, 3'd0, 2'd0);
        chk("ar_pending", dout_valid, 1);
        dout_ready = 1'b1;
        do_reset();
        send(16'h7777, 3'd1, 2'd0);
        chk("ar_delay_first", dout, 16'h0000);

        // Reserved modes
        send(16'hABCD, 3'd7, 2'd0);
        chk("mode7", dout, 16'hABCD);
        send(16'h1357, 3'd6, 2'd2);
        chk("mode6", dout, 16'h1357);

        // Counter wrap
        do_reset();
        for (int i = 0; i < 65535; i++) begin
            send(16'(i), 3'd7, 2'd0);
        end
        chk("count_ffff", count, 16'hFFFF);
        send(16'hBEEF, 3'd7, 2'd0);
        chk("count_wrap", count, 16'h0000);
        chk("wrap_dout", dout, 16'hBEEF);

        // Drain and check every result came out exactly once
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb_q.size(), 0);
        chk("sb_pop_count", n_pop, n_push);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
